// File: rtl/led_ctrl_seq.sv
// led_ctrl_seq: opcode-driven sequencer for external LED driver chips.
// Takes 32-bit instructions over valid/ready, shifts buffered data out
// MSB first on serial/sclk, pulses one latch line and runs a free-running
// prescaled gsclk.
module led_ctrl_seq #(
  parameter int N_LAT     = 4,
  parameter int DATA_W    = 16,
  parameter int LAT_TICKS = 3,
  parameter int PSC_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instruction,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic              serial,
  output logic              sclk,
  output logic [N_LAT-1:0]  lat,
  output logic              gsclk,
  output logic [3:0]        state,
  output logic              busy
);

  localparam int BIT_W  = (DATA_W > 1)    ? $clog2(DATA_W)    : 1;
  localparam int TICK_W = (LAT_TICKS > 1) ? $clog2(LAT_TICKS) : 1;
  localparam logic [N_LAT-1:0] LAT_ONE = 1;
  localparam logic [7:0]       N_LAT8  = 8'(N_LAT);

  localparam logic [7:0] OP_BUFFER = 8'd1;
  localparam logic [7:0] OP_SEND   = 8'd2;
  localparam logic [7:0] OP_LATCH  = 8'd4;
  localparam logic [7:0] OP_PSC    = 8'd8;

  typedef enum logic [3:0] {
    READY    = 4'd0,
    WAIT_LAT = 4'd1,
    SHIFT_LO = 4'd2,
    SHIFT_HI = 4'd3
  } state_t;

  state_t             st;
  logic [DATA_W-1:0]  shift_buf;
  logic [BIT_W-1:0]   bit_cnt;
  logic [TICK_W-1:0]  tick;
  logic [PSC_W-1:0]   psc, psc_cnt;

  logic [7:0] op_code, index;
  logic       accept;

  assign op_code     = instruction[31:24];
  assign index       = instruction[23:16];
  assign instr_ready = (st == READY) && !rst;
  assign accept      = instr_valid && instr_ready;
  assign state       = st;
  assign busy        = (st != READY);

  // Main sequencer: decodes opcodes in READY, walks the shift and latch phases.
  // Serial is loaded on the transition into SHIFT_LO so each bit is already
  // stable when sclk rises one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= READY;
      shift_buf <= '0;
      bit_cnt   <= '0;
      tick      <= '0;
      serial    <= 1'b0;
      sclk      <= 1'b0;
      lat       <= '0;
    end else begin
      case (st)
        READY: begin
          if (instr_valid) begin
            case (op_code)
              OP_BUFFER: shift_buf <= instruction[DATA_W-1:0];
              OP_SEND: begin
                bit_cnt <= BIT_W'(DATA_W - 1);
                serial  <= shift_buf[DATA_W-1];
                sclk    <= 1'b0;
                st      <= SHIFT_LO;
              end
              OP_LATCH: begin
                // Out-of-range indices are swallowed without side effects.
                if (index < N_LAT8) begin
                  lat  <= LAT_ONE << index;
                  tick <= TICK_W'(LAT_TICKS - 1);
                  st   <= WAIT_LAT;
                end
              end
              default: ;
            endcase
          end
        end
        SHIFT_LO: begin
          sclk <= 1'b1;
          st   <= SHIFT_HI;
        end
        SHIFT_HI: begin
          sclk <= 1'b0;
          if (bit_cnt == '0) begin
            st <= READY;
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
            serial  <= shift_buf[bit_cnt - 1'b1];
            st      <= SHIFT_LO;
          end
        end
        WAIT_LAT: begin
          if (tick == '0) begin
            lat <= '0;
            st  <= READY;
          end else begin
            tick <= tick - 1'b1;
          end
        end
        default: st <= READY;
      endcase
    end
  end

  // Grayscale clock prescaler: toggles every psc cycles, held low when psc==0.
  // A new prescale value restarts the count from zero with gsclk low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psc     <= '0;
      psc_cnt <= '0;
      gsclk   <= 1'b0;
    end else if (accept && op_code == OP_PSC) begin
      psc     <= instruction[PSC_W-1:0];
      psc_cnt <= '0;
      gsclk   <= 1'b0;
    end else if (psc == '0) begin
      psc_cnt <= '0;
      gsclk   <= 1'b0;
    end else if (psc_cnt == psc - 1'b1) begin
      psc_cnt <= '0;
      gsclk   <= ~gsclk;
    end else begin
      psc_cnt <= psc_cnt + 1'b1;
    end
  end

endmodule
